// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes and
// the ALU operand/operation selects seen by the datapath.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // States that stall on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating memory-wait counter; flags the cycle in which another stalled
// cycle would bring the count up to MEM_TIMEOUT.
module wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned    CW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0]  MAX  = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != MAX))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hit_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle control FSM for a small RISC-V subset, with a memory
// wait timeout and sticky illegal/mem_fault flags.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       branch_taken,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       mem_fault,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_fault_q, mem_fault_d;
  logic   is_store_q;
  logic   tmr_hit;

  wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_d != state_q),
    .inc_i   (is_wait_state(state_q) && !mem_ready),
    .hit_o   (tmr_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Load/store direction is opcode bit 5; opcode is only valid in DECODE.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) is_store_q <= opcode[5];
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    mem_fault_d = mem_fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (tmr_hit) begin
          state_d     = S_FAULT;
          mem_fault_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL: begin
            if (EN_JAL) state_d = S_JAL;
            else begin
              state_d   = S_FAULT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:             state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        else if (tmr_hit) begin
          state_d     = S_FAULT;
          mem_fault_d = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
  end

  // FETCH and BRANCH qualify their write strobes with the handshake/flag.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: mem_read  = 1'b1;
      S_MEM_WR: mem_write = 1'b1;
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_SUB;
        branch_taken = zero;
        pc_write     = zero;
      end
      S_JAL: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign mem_fault = mem_fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded directed bench: one instance with MEM_TIMEOUT=4/EN_JAL=1 and
// one with EN_JAL=0; each cycle's expected state and control vector is queued.
module tb_multicycle_control_unit;
  import control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, zero, mem_ready;
  logic [6:0] opcode;

  logic       pcw0, irw0, mr0, mw0, mtr0, rw0, bt0, ill0, mf0;
  logic [1:0] sa0, sb0, op0;
  logic [3:0] st0;
  logic       pcw1, irw1, mr1, mw1, mtr1, rw1, bt1, ill1, mf1;
  logic [1:0] sa1, sb1, op1;
  logic [3:0] st1;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .EN_JAL(1'b1)) u_dut (
    .clk(clk), .rst(rst0), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw0), .ir_write(irw0), .mem_read(mr0), .mem_write(mw0),
    .mem_to_reg(mtr0), .reg_write(rw0), .branch_taken(bt0),
    .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(op0),
    .illegal(ill0), .mem_fault(mf0), .state_o(st0)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(16), .EN_JAL(1'b0)) u_nojal (
    .clk(clk), .rst(rst1), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw1), .ir_write(irw1), .mem_read(mr1), .mem_write(mw1),
    .mem_to_reg(mtr1), .reg_write(rw1), .branch_taken(bt1),
    .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(op1),
    .illegal(ill1), .mem_fault(mf1), .state_o(st1)
  );

  // {pc_write, ir_write, mem_read, mem_write, mem_to_reg, reg_write,
  //  branch_taken, alu_src_a, alu_src_b, alu_op, illegal, mem_fault}
  logic [14:0] ov0, ov1;
  assign ov0 = {pcw0, irw0, mr0, mw0, mtr0, rw0, bt0, sa0, sb0, op0, ill0, mf0};
  assign ov1 = {pcw1, irw1, mr1, mw1, mtr1, rw1, bt1, sa1, sb1, op1, ill1, mf1};

  localparam logic [14:0] FW  = 15'b0010000_00_10_00_0_0;
  localparam logic [14:0] FR  = 15'b1110000_00_10_00_0_0;
  localparam logic [14:0] DEC = 15'b0000000_00_00_00_0_0;
  localparam logic [14:0] EXR = 15'b0000000_01_00_10_0_0;
  localparam logic [14:0] EXI = 15'b0000000_01_01_10_0_0;
  localparam logic [14:0] ADR = 15'b0000000_01_01_00_0_0;
  localparam logic [14:0] MRD = 15'b0010000_00_00_00_0_0;
  localparam logic [14:0] MWR = 15'b0001000_00_00_00_0_0;
  localparam logic [14:0] WBA = 15'b0000010_00_00_00_0_0;
  localparam logic [14:0] WBM = 15'b0000110_00_00_00_0_0;
  localparam logic [14:0] BRT = 15'b1000001_01_00_01_0_0;
  localparam logic [14:0] BRN = 15'b0000000_01_00_01_0_0;
  localparam logic [14:0] JLV = 15'b1000010_10_01_00_0_0;
  localparam logic [14:0] FIL = 15'b0000000_00_00_00_1_0;
  localparam logic [14:0] FMF = 15'b0000000_00_00_00_0_1;

  localparam logic [6:0] OPX = 7'b0000000;
  localparam logic [6:0] OPBAD = 7'b1111111;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [14:0] ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  task automatic step(input bit which, input logic r, input logic [6:0] op,
                      input logic z, input logic rdy, input state_t est,
                      input logic [14:0] eov);
    exp_t e;
    @(posedge clk);
    #1;
    if (!which) begin rst0 = r; rst1 = 1'b1; end
    else        begin rst1 = r; rst0 = 1'b1; end
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    step_no++;
    e.idx = step_no;
    e.st  = est;
    e.ov  = eov;
    if (!which) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        n_checks++;
        if (st0 === e.st && ov0 === e.ov) n_pass++;
        else $display("FAIL dut0 step %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                      e.idx, st0, ov0, e.st, e.ov);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        n_checks++;
        if (st1 === e.st && ov1 === e.ov) n_pass++;
        else $display("FAIL nojal step %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                      e.idx, st1, ov1, e.st, e.ov);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    rst0 = 1'b1; rst1 = 1'b1; opcode = OPX; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    // reset state, then R-type
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_RTYPE,  0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 1, S_EXEC_R, EXR);
    step(0, 0, OPX,       0, 1, S_WB_ALU, WBA);
    // I-type
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_ITYPE,  0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 1, S_EXEC_I, EXI);
    step(0, 0, OPX,       0, 1, S_WB_ALU, WBA);
    // LW, three wait cycles; ready arrives on the cycle the timeout would fire
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_LOAD,   0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 0, S_ADDR,   ADR);
    step(0, 0, OPX,       0, 0, S_MEM_RD, MRD);
    step(0, 0, OPX,       0, 0, S_MEM_RD, MRD);
    step(0, 0, OPX,       0, 0, S_MEM_RD, MRD);
    step(0, 0, OPX,       0, 1, S_MEM_RD, MRD);
    step(0, 0, OPX,       0, 1, S_WB_MEM, WBM);
    // SW
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_STORE,  0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 1, S_ADDR,   ADR);
    step(0, 0, OPX,       0, 1, S_MEM_WR, MWR);
    // BEQ taken, then not taken
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_BRANCH, 0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       1, 1, S_BRANCH, BRT);
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_BRANCH, 0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 1, S_BRANCH, BRN);
    // JAL enabled
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_JAL,    0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 1, S_JAL,    JLV);
    // illegal opcode, FAULT absorbing, cleared by rst
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OPBAD,     0, 1, S_DECODE, DEC);
    step(0, 0, OP_RTYPE,  1, 1, S_FAULT,  FIL);
    step(0, 0, OP_RTYPE,  1, 1, S_FAULT,  FIL);
    step(0, 1, OPX,       0, 0, S_FAULT,  FIL);
    // fetch timeout after 4 stalled cycles
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    step(0, 0, OPX,       0, 0, S_FAULT,  FMF);
    step(0, 1, OPX,       0, 1, S_FAULT,  FMF);
    // reset during the second MEM_WR wait cycle
    step(0, 0, OPX,       0, 1, S_FETCH,  FR);
    step(0, 0, OP_STORE,  0, 1, S_DECODE, DEC);
    step(0, 0, OPX,       0, 0, S_ADDR,   ADR);
    step(0, 0, OPX,       0, 0, S_MEM_WR, MWR);
    step(0, 1, OPX,       0, 0, S_MEM_WR, MWR);
    step(0, 0, OPX,       0, 0, S_FETCH,  FW);
    // EN_JAL=0 instance: JAL is illegal, I-type still works after reset
    step(1, 0, OPX,       0, 1, S_FETCH,  FR);
    step(1, 0, OP_JAL,    0, 1, S_DECODE, DEC);
    step(1, 0, OPX,       0, 1, S_FAULT,  FIL);
    step(1, 1, OPX,       0, 1, S_FAULT,  FIL);
    step(1, 0, OPX,       0, 1, S_FETCH,  FR);
    step(1, 0, OP_ITYPE,  0, 1, S_DECODE, DEC);
    step(1, 0, OPX,       0, 1, S_EXEC_I, EXI);
    step(1, 0, OPX,       0, 1, S_WB_ALU, WBA);

    for (int i = 0; i < 4 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    #1;
    if ((q0.size() + q1.size()) > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
